i2s_rx_capture: RTL

//  I2S receive (capture) path: deserialises stereo 16-bit audio from an external ADC/codec line
//  and buffers frames in a FIFO for CPU readout over Wishbone.

---
 rtl/i2s_rx_capture.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/i2s_rx_capture.sv
// i2s_rx_capture: I2S stereo 16-bit capture into a frame FIFO with Wishbone readout.
// Define I2S_RX_OVFCNT_EN to implement the dropped-frame counter at register 3.
module i2s_rx_capture #(
  parameter int unsigned FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic        i2s_sclk,
  input  logic        i2s_lrclk,
  input  logic        i2s_sdin,
  output logic        fifo_high
);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned PW    = FIFO_AW + 1;
  localparam int unsigned WW    = 16;
  localparam int unsigned CW    = 5;

  logic [2:0]      sclk_q;
  logic [1:0]      lrclk_q;
  logic [1:0]      sdin_q;
  logic            ctrl_en;
  logic [7:0]      thr;
  logic            ovf;
  logic            lr_prev;
  logic            synced;
  logic            left_ok;
  logic [WW-1:0]   shreg;
  logic [WW-1:0]   shreg_nxt;
  logic [WW-1:0]   left_word;
  logic [CW-1:0]   bit_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   level;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     status_c;
  logic [31:0]     rdata_c;
  logic [15:0]     ovfcnt_c;
  logic            sclk_rise;
  logic            lr_now;
  logic            push_req;
  logic            do_push;
  logic            drop;
  logic            pop;
  logic            empty;
  logic            full;
  logic            wb_req;
  logic            wb_wr;
  logic            wb_rd;
  logic [1:0]      reg_sel;
  logic            unused_ok;

  assign unused_ok = ^{wb_adr_i, wb_sel_i, wb_dat_i};

  // Pad synchronisers; sclk keeps one extra stage for rise detection
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sclk_q  <= '0;
      lrclk_q <= '0;
      sdin_q  <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], i2s_sclk};
      lrclk_q <= {lrclk_q[0], i2s_lrclk};
      sdin_q  <= {sdin_q[0], i2s_sdin};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign lr_now    = lrclk_q[1];

  // Place the incoming bit MSB first; bits past the 16th are dropped
  always_comb begin
    shreg_nxt = shreg;
    if (bit_cnt < CW'(WW)) shreg_nxt[~bit_cnt[3:0]] = sdin_q[1];
  end

  // The bit on the first rise after an lrclk change is the LSB of the previous word
  assign push_req = ctrl_en & sclk_rise & lr_prev & ~lr_now & left_ok;

  always_ff @(posedge clk) begin
    if (!rstn || !ctrl_en) begin
      lr_prev   <= 1'b0;
      synced    <= 1'b0;
      left_ok   <= 1'b0;
      shreg     <= '0;
      left_word <= '0;
      bit_cnt   <= '0;
    end else if (sclk_rise) begin
      lr_prev <= lr_now;
      if (lr_now != lr_prev) begin
        shreg   <= '0;
        bit_cnt <= '0;
        if (!lr_now) begin
          synced <= 1'b1;
        end else if (synced) begin
          left_word <= shreg_nxt;
          left_ok   <= 1'b1;
        end
      end else begin
        shreg <= shreg_nxt;
        if (bit_cnt < CW'(WW)) bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  assign wb_req  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wb_wr   = wb_req & wb_we_i;
  assign wb_rd   = wb_req & ~wb_we_i;
  assign reg_sel = wb_adr_i[3:2];

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == PW'(DEPTH));
  assign pop     = wb_rd & (reg_sel == 2'd0) & ~empty;
  assign do_push = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= {left_word, shreg_nxt};
  end

  // Disabling flushes the FIFO by clearing both pointers
  always_ff @(posedge clk) begin
    if (!rstn || !ctrl_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctrl_en   <= 1'b0;
      thr       <= '0;
      ovf       <= 1'b0;
      fifo_high <= 1'b0;
    end else begin
      if (wb_wr && reg_sel == 2'd2) begin
        ctrl_en <= wb_dat_i[0];
        thr     <= wb_dat_i[15:8];
      end
      if (drop) ovf <= 1'b1;
      else if (wb_wr && reg_sel == 2'd1 && wb_dat_i[2]) ovf <= 1'b0;
      fifo_high <= ctrl_en & (thr != '0) & (8'(level) >= thr);
    end
  end

`ifdef I2S_RX_OVFCNT_EN
  logic [15:0] ovf_cnt;

  // Clear wins over a coincident drop
  always_ff @(posedge clk) begin
    if (!rstn) ovf_cnt <= '0;
    else if (wb_wr && reg_sel == 2'd3) ovf_cnt <= '0;
    else if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
  end

  assign ovfcnt_c = ovf_cnt;
`else
  assign ovfcnt_c = 16'h0;
`endif

  always_comb begin
    status_c         = '0;
    status_c[0]      = empty;
    status_c[1]      = full;
    status_c[2]      = ovf;
    status_c[3]      = fifo_high;
    status_c[8 +: PW] = level;
  end

  always_comb begin
    rdata_c = '0;
    case (reg_sel)
      2'd0:    if (!empty) rdata_c = mem[rd_ptr[FIFO_AW-1:0]];
      2'd1:    rdata_c = status_c;
      2'd2:    rdata_c = {16'h0, thr, 7'h0, ctrl_en};
      default: rdata_c = {16'h0, ovfcnt_c};
    endcase
  end

  // Single-cycle ack with data registered alongside; data is zero outside a read ack
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_req;
      wb_dat_o <= wb_rd ? rdata_c : 32'h0;
    end
  end

endmodule
